// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding and the
// counter-width helper used to size the beat counter.
package psum_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Ceiling log2; the counter must represent 0..MAX_PASSES, so callers pass MAX_PASSES+1.
  function automatic int psum_clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// One accumulator lane: sign-extended add at OUT_W+1 bits with saturate or
// wrap on the result and an overflow indication for the sticky flag.
module psum_lane_add #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 21
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  input  logic             sat_en,
  output logic [OUT_W-1:0] sum,
  output logic             ovf
);

  logic [OUT_W:0] acc_x;
  logic [OUT_W:0] add_x;
  logic [OUT_W:0] wide;

  assign acc_x = {acc[OUT_W-1], acc};
  assign add_x = {{(OUT_W + 1 - IN_W){addend[IN_W-1]}}, addend};
  assign wide  = acc_x + add_x;

  // The extra bit disagreeing with the OUT_W sign bit means the result left range.
  assign ovf = wide[OUT_W] ^ wide[OUT_W-1];

  always_comb begin
    sum = wide[OUT_W-1:0];
    if (ovf && sat_en) begin
      if (wide[OUT_W]) begin
        sum = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
        sum = {1'b0, {(OUT_W - 1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Multi-lane partial-sum accumulator: sums N beats per group, then holds the
// result until the consumer takes it, with zero-bubble back-to-back groups.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int IN_W       = 18,
  parameter int OUT_W      = 21,
  parameter int LANES      = 64,
  parameter int MAX_PASSES = 8,
  localparam int CNT_W     = psum_clog2(MAX_PASSES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [CNT_W-1:0]       num_passes,
  input  logic                   sat_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W*LANES-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic                   busy
);

  logic [1:0]             state_reg;
  logic [OUT_W*LANES-1:0] acc_reg;
  logic [LANES-1:0]       ovf_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       n_reg;
  logic                   sat_reg;

  logic                   in_xfer;
  logic                   out_xfer;
  logic                   load;
  logic                   lane_sat;
  logic [CNT_W-1:0]       n_eff;
  logic [CNT_W-1:0]       count_inc;
  logic [OUT_W*LANES-1:0] sum_all;
  logic [LANES-1:0]       lane_ovf;

  assign in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_ACCUM) ||
                     ((state_reg == ST_HOLD) && out_ready);
  assign out_valid = (state_reg == ST_HOLD);
  assign busy      = (state_reg != ST_IDLE);
  assign out_data  = acc_reg;
  assign out_ovf   = ovf_reg;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // In HOLD in_ready follows out_ready, so a beat there always coincides with a result transfer.
  assign load      = in_xfer && ((state_reg == ST_IDLE) || (state_reg == ST_HOLD));
  assign lane_sat  = load ? sat_en : sat_reg;
  assign count_inc = count_reg + CNT_W'(1);

  always_comb begin
    n_eff = num_passes;
    if (num_passes == '0) begin
      n_eff = CNT_W'(1);
    end else if (num_passes > CNT_W'(MAX_PASSES)) begin
      n_eff = CNT_W'(MAX_PASSES);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane
      logic [OUT_W-1:0] acc_in;

      // A group load starts from zero so the first beat is simply sign-extended.
      assign acc_in = load ? '0 : acc_reg[OUT_W*gi +: OUT_W];

      psum_lane_add #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_lane_add (
        .acc    (acc_in),
        .addend (in_data[IN_W*gi +: IN_W]),
        .sat_en (lane_sat),
        .sum    (sum_all[OUT_W*gi +: OUT_W]),
        .ovf    (lane_ovf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      ovf_reg   <= '0;
      count_reg <= '0;
      n_reg     <= CNT_W'(1);
      sat_reg   <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      ovf_reg   <= '0;
      count_reg <= '0;
    end else if (load) begin
      acc_reg   <= sum_all;
      ovf_reg   <= '0;
      count_reg <= CNT_W'(1);
      n_reg     <= n_eff;
      sat_reg   <= sat_en;
      state_reg <= (n_eff == CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
    end else if ((state_reg == ST_ACCUM) && in_xfer) begin
      acc_reg   <= sum_all;
      ovf_reg   <= ovf_reg | lane_ovf;
      count_reg <= count_inc;
      if (count_inc == n_reg) begin
        state_reg <= ST_HOLD;
      end
    end else if ((state_reg == ST_HOLD) && out_xfer) begin
      state_reg <= ST_IDLE;
    end else if ((state_reg != ST_IDLE) && (state_reg != ST_ACCUM) &&
                 (state_reg != ST_HOLD)) begin
      state_reg <= ST_IDLE;
    end
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter IN_W, default 18, width of one signed partial-sum lane.
REQ-002 SHALL have parameter OUT_W, default 21, width of one accumulated lane (OUT_W >= IN_W).
REQ-003 SHALL have parameter LANES, default 64, number of parallel lanes.
REQ-004 SHALL have parameter MAX_PASSES, default 8, maximum beats per group; CNT_W = clog2(MAX_PASSES+1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous abort of the current group.
REQ-008 SHALL have port num_passes  input  CNT_W  beats per group, sampled on the first beat of a group.
REQ-009 SHALL have port sat_en  input  1  saturating (1) or wrapping (0) accumulation, sampled on the first beat of a group.
REQ-010 SHALL have port in_valid  input  1  in_data is valid.
REQ-011 SHALL have port in_ready  output  1  block accepts in_data.
REQ-012 SHALL have port in_data  input  IN_W*LANES  lane i at bits [IN_W*(i+1)-1 -: IN_W], two's complement.
REQ-013 SHALL have port out_valid  output  1  result is available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port out_data  output  OUT_W*LANES  registered per-lane sums, same lane packing as in_data.
REQ-016 SHALL have port out_ovf  output  LANES  per-lane sticky overflow flag for the delivered group.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-018 SHALL transfer a beat on in_valid && in_ready and a result on out_valid && out_ready.
REQ-019 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-020 SHALL, in IDLE: in_ready=1; a transfer loads acc=sext(in_data), count=1 and latches N=max(num_passes,1) (values above MAX_PASSES clamp to MAX_PASSES); next state is HOLD if N==1, else ACCUM.
REQ-021 SHALL, in ACCUM: in_ready=1; each transfer sets acc+=sext(in_data) per lane and count+=1; the transfer making count==N moves to HOLD; a cycle without in_valid holds all state.
REQ-022 SHALL, in HOLD: out_valid=1; out_data and out_ovf stable until the result transfers.
REQ-023 SHALL, in HOLD: in_ready=out_ready; a simultaneous result transfer and beat transfer starts a new group exactly as the IDLE load (zero bubble); a result transfer with no beat returns to IDLE.
REQ-024 SHALL assert out_valid on the cycle after the final beat transfers (latency 1).
REQ-025 SHALL add per lane at OUT_W+1 bits; with sat_en=1, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; with sat_en=0, wrap modulo 2^OUT_W.
REQ-026 SHALL set out_ovf[i] when any addition of lane i in the group leaves the OUT_W range, in either mode; the flag clears on the next group load.
REQ-027 SHALL, on flush=1, enter IDLE, clear acc, count and out_ovf, and force out_valid=0 the next cycle; flush overrides any same-cycle transfer, and a beat presented with flush is dropped.
REQ-028 SHALL keep the num_passes and sat_en values latched at group start for the whole group, ignoring mid-group changes.

Reset
REQ-029 SHALL, while rst_n=0: state=IDLE, acc=0, count=0, out_ovf=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-030 SHALL discard any partial group on reset mid-operation, with no output produced for it.

Structure
REQ-031 SHALL place the FSM state encoding and the CNT_W/clog2 helper in the shared package psum_pkg.
REQ-032 SHALL instantiate one sub-module psum_lane_add per lane: combinational sext-add with saturate/wrap select and overflow flag.

Verification
REQ-033 SHALL cover N=8, all lanes +1000 per beat, out_ready=1 -> out_data lanes=8000, out_valid 1 cycle after beat 8, out_ovf=0.
REQ-034 SHALL cover OUT_W=18, sat_en=1, N=2, lane0 = 131071 then 1 -> lane0=131071, out_ovf[0]=1; same with sat_en=0 -> lane0=-131072, out_ovf[0]=1.
REQ-035 SHALL cover N=1, continuous in_valid, out_ready=1 -> one result per cycle, no bubbles, each equal to its input sign-extended.
REQ-036 SHALL cover holding out_ready=0 for 5 cycles in HOLD -> in_ready=0, out_data stable, next group's beats stalled then accepted.
REQ-037 SHALL cover flush after beat 3 of N=4, then a fresh group of 4 beats of -5 -> first group never output, second gives -20.
REQ-038 SHALL cover rst_n pulsed low mid-ACCUM -> all outputs at reset values, next group result unaffected by pre-reset beats.
